// File: rtl/squared_distance_pkg.sv
// Shared types and widths for the squared_distance stage.
// Default widths match the square-root unit's A input (8.4 format).
package squared_distance_pkg;

  localparam int SQDIST_IN_INT_B = 5;
  localparam int SQDIST_IN_FP_B  = 2;
  localparam int SQDIST_IN_B     = SQDIST_IN_INT_B + SQDIST_IN_FP_B;
  localparam int SQDIST_ACC_B    = 2 * SQDIST_IN_B;

  localparam int SQRT_A_INT_B = 8;
  localparam int SQRT_A_FP_B  = 4;
  localparam int SQRT_A_B     = SQRT_A_INT_B + SQRT_A_FP_B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } SQDIST_STATE;

  // Bit-index width for a W-bit multiplier operand.
  function automatic int sqdist_idx_b(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/squared_distance_serial_square.sv
// Serial shift-add squarer: one multiplier bit per step.
// Holds one magnitude and its bit index; emits the partial product.
module squared_distance_serial_square
  import squared_distance_pkg::*;
#(
  parameter int W     = SQDIST_IN_B,
  parameter int ACC_B = 2 * W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     mag_in,
  output logic [ACC_B-1:0] pp,
  output logic             last
);

  localparam int IB = sqdist_idx_b(W);

  logic [W-1:0]  mag;
  logic [IB-1:0] idx;

  assign last = (idx == IB'(W - 1));

  // Operand register and bit counter; a load restarts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
      idx <= '0;
    end else if (clear) begin
      mag <= '0;
      idx <= '0;
    end else if (load) begin
      mag <= mag_in;
      idx <= '0;
    end else if (step) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  // Partial product: mag shifted by the current bit when that bit is set.
  always_comb begin
    pp = '0;
    if (mag[idx])
      pp = ACC_B'(mag) << idx;
  end

endmodule

// File: rtl/squared_distance.sv
// Iterative dx^2+dy^2+dz^2 feeding the square-root unit's A input.
// Optional macro SQDIST_SATURATE_EN clamps Q to all ones on overflow.
module squared_distance
  import squared_distance_pkg::*;
#(
  parameter int IN_INT_B = SQDIST_IN_INT_B,
  parameter int IN_FP_B  = SQDIST_IN_FP_B,
  parameter int A_INT_B  = SQRT_A_INT_B,
  parameter int A_FP_B   = SQRT_A_FP_B,
  parameter int W        = IN_INT_B + IN_FP_B,
  parameter int ACC_B    = 2 * W,
  parameter int QW       = A_INT_B + A_FP_B
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dx,
  input  logic [W-1:0]  dy,
  input  logic [W-1:0]  dz,
  output logic          busy,
  output logic          out_valid,
  output logic [QW-1:0] Q
);

  SQDIST_STATE      state;
  logic [W-1:0]     d_r [3];
  logic [W-1:0]     mag1;
  logic [W-1:0]     mag2;
  logic [W-1:0]     abs_d [3];
  logic [1:0]       comp;
  logic [ACC_B-1:0] acc;
  logic [ACC_B-1:0] sum;
  logic [ACC_B-1:0] pp;
  logic             sq_last;
  logic             sq_load;
  logic             sq_step;
  logic             sq_clear;
  logic [W-1:0]     sq_mag;
  logic [QW-1:0]    q_trunc;
  logic [QW-1:0]    q_next;

  // Magnitudes of the captured operands; -2^(W-1) maps to 2^(W-1).
  always_comb begin
    for (int i = 0; i < 3; i++)
      abs_d[i] = d_r[i][W-1] ? (~d_r[i] + 1'b1) : d_r[i];
  end

  assign sum = acc + pp;

  // Squarer control: first operand in LOAD, next one on each wrap.
  always_comb begin
    sq_clear = (state == DONE);
    sq_step  = (state == MUL);
    sq_load  = (state == LOAD) ||
               ((state == MUL) && sq_last && (comp != 2'd2));
    sq_mag   = abs_d[0];
    if (state != LOAD)
      sq_mag = (comp == 2'd0) ? mag1 : mag2;
  end

  squared_distance_serial_square #(
    .W     (W),
    .ACC_B (ACC_B)
  ) u_sq (
    .clk    (clk),
    .rst    (rst),
    .clear  (sq_clear),
    .load   (sq_load),
    .step   (sq_step),
    .mag_in (sq_mag),
    .pp     (pp),
    .last   (sq_last)
  );

  generate
    if (ACC_B >= QW) begin : g_trunc
      assign q_trunc = sum[QW-1:0];
    end else begin : g_pad
      assign q_trunc = QW'(sum);
    end
  endgenerate

`ifdef SQDIST_SATURATE_EN
  logic sat_hit;

  generate
    if (ACC_B > QW) begin : g_sat
      assign sat_hit = |sum[ACC_B-1:QW];
    end else begin : g_nosat
      assign sat_hit = 1'b0;
    end
  endgenerate

  assign q_next = sat_hit ? '1 : q_trunc;
`else
  assign q_next = q_trunc;
`endif

  // Control FSM with registered busy, out_valid and Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_r[0]    <= '0;
      d_r[1]    <= '0;
      d_r[2]    <= '0;
      mag1      <= '0;
      mag2      <= '0;
      comp      <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      Q         <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_r[0] <= dx;
            d_r[1] <= dy;
            d_r[2] <= dz;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          mag1  <= abs_d[1];
          mag2  <= abs_d[2];
          acc   <= '0;
          comp  <= '0;
          state <= MUL;
        end
        MUL: begin
          acc <= sum;
          if (sq_last) begin
            if (comp == 2'd2) begin
              Q         <= q_next;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              comp <= comp + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_squared_distance.sv
// Randomized and directed bench for squared_distance.
// Reference: signed sum of squares, wrapped or clamped to 12 bits.
module tb_squared_distance;

  localparam int W   = 7;
  localparam int QW  = 12;
  localparam int LAT = 3 * W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dx;
  logic [W-1:0]  dy;
  logic [W-1:0]  dz;
  logic          busy;
  logic          out_valid;
  logic [QW-1:0] q;

  int n_chk  = 0;
  int n_pass = 0;

  squared_distance dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dx        (dx),
    .dy        (dy),
    .dz        (dz),
    .busy      (busy),
    .out_valid (out_valid),
    .Q         (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int model(input int a, input int b, input int c);
    int s;
    s = a * a + b * b + c * c;
`ifdef SQDIST_SATURATE_EN
    if (s >= (1 << QW))
      return (1 << QW) - 1;
    return s;
`else
    return s % (1 << QW);
`endif
  endfunction

  // One request; s1/s2 are cycles where start is re-asserted.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input int s1,
                     input int s2, input string tag);
    int exp;
    int lat;
    int pulses;
    int busy_bad;
    int qv;
    exp      = model(sx(a), sx(b), sx(c));
    lat      = -1;
    pulses   = 0;
    busy_bad = 0;
    qv       = -1;
    @(negedge clk);
    dx    = a;
    dy    = b;
    dz    = c;
    start = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      @(negedge clk);
      start = (k == s1) || (k == s2);
      if (k == 1) begin
        dx = 7'($urandom_range(0, 127));
        dy = 7'($urandom_range(0, 127));
        dz = 7'($urandom_range(0, 127));
      end
      if (busy != (k <= LAT - 1))
        busy_bad++;
      if (out_valid) begin
        pulses++;
        lat = k;
        qv  = int'(q);
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, lat, LAT);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".busy"}, busy_bad, 0);
    check({tag, ".q"}, qv, exp);
    check({tag, ".hold"}, int'(q), exp);
  endtask

  // Reset asserted mid-run aborts the request silently.
  task automatic reset_mid_run();
    int pulses;
    pulses = 0;
    @(negedge clk);
    dx    = 7'd20;
    dy    = 7'd12;
    dz    = 7'd3;
    start = 1'b1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid)
        pulses++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.q", int'(q), 0);
    check("rstmid.ov", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (out_valid)
        pulses++;
    end
    check("rstmid.pulses", pulses, 0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    rst   = 1'b1;
    start = 1'b0;
    dx    = '0;
    dy    = '0;
    dz    = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.ov", int'(out_valid), 0);
    check("reset.q", int'(q), 0);
    rst = 1'b0;

    run(7'd4, 7'd8, 7'd8, 0, 0, "t_9p0");
    run(7'(-12), 7'd0, 7'd16, 0, 0, "t_sign");
    run(7'd1, 7'd0, 7'd0, 0, 0, "t_lsb");
    run(7'd0, 7'd0, 7'd0, 0, 0, "t_zero");
    run(7'(-64), 7'(-64), 7'(-64), 0, 0, "t_max");
    run(7'd5, 7'(-7), 7'd3, 5, 22, "t_restart");
    run(7'(-9), 7'd11, 7'(-2), 3, 23, "t_done_start");

    for (int i = 0; i < 10; i++) begin
      a = 7'($urandom_range(0, 127));
      b = 7'($urandom_range(0, 127));
      c = 7'($urandom_range(0, 127));
      run(a, b, c, 0, 0, $sformatf("rnd%0d", i));
    end

    reset_mid_run();
    run(7'd4, 7'd8, 7'd8, 0, 0, "t_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
